// File: rtl/snitch_pkg.sv
// Shared Snitch definitions: atomic opcodes and the LRWAIT reservation queue states.
package snitch_pkg;

  typedef enum logic [3:0] {
    AMONone   = 4'h0,
    AMOSwap   = 4'h1,
    AMOAdd    = 4'h2,
    AMOAnd    = 4'h3,
    AMOOr     = 4'h4,
    AMOXor    = 4'h5,
    AMOMax    = 4'h6,
    AMOMaxu   = 4'h7,
    AMOMin    = 4'h8,
    AMOMinu   = 4'h9,
    AMOLR     = 4'hA,
    AMOSC     = 4'hB,
    LRWAIT    = 4'hC,
    SCWAIT    = 4'hD
  } amo_op_t;

  typedef enum logic [1:0] {
    QFree       = 2'd0,
    QLocked     = 2'd1,
    QWaitWakeUp = 2'd2
  } lrwait_state_e;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with the common_cells fifo_v3 port list (no fall-through mode).
module fifo_v3 #(
  parameter int unsigned DEPTH      = 8,
  parameter type         dtype      = logic [31:0],
  parameter int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  dtype                  data_i,
  input  logic                  push_i,
  output dtype                  data_o,
  input  logic                  pop_i
);

  dtype                  mem_q [DEPTH];
  logic [ADDR_DEPTH-1:0] rd_ptr_q, wr_ptr_q;
  logic [ADDR_DEPTH:0]   cnt_q;
  logic                  push_en, pop_en;
  logic                  unused_testmode;

  assign unused_testmode = testmode_i;
  assign full_o  = (cnt_q == (ADDR_DEPTH+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign usage_o = cnt_q[ADDR_DEPTH-1:0];
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  function automatic logic [ADDR_DEPTH-1:0] incr(input logic [ADDR_DEPTH-1:0] p);
    return (p == ADDR_DEPTH'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: sequential state is updated with non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_en) wr_ptr_q <= incr(wr_ptr_q);
      if (pop_en)  rd_ptr_q <= incr(rd_ptr_q);
      if (push_en && !pop_en)      cnt_q <= cnt_q + 1'b1;
      else if (pop_en && !push_en) cnt_q <= cnt_q - 1'b1;
    end
  end

  // NOTE: storage has no reset; an entry is only observable after it has been written.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/lrwait_queue_ctrl.sv
// LRWAIT/SCWAIT reservation queue in front of one memory bank, with a 2-entry response FIFO.
module lrwait_queue_ctrl
  import snitch_pkg::*;
#(
  parameter type         metadata_t = logic,
  parameter int unsigned AddrWidth  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_write_i,
  input  amo_op_t              req_amo_i,
  input  logic [31:0]          req_wdata_i,
  input  logic [3:0]           req_be_i,
  input  metadata_t            req_meta_i,
  input  logic                 req_lrwait_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [31:0]          resp_rdata_o,
  output metadata_t            resp_meta_o,
  output logic                 resp_lrwait_o,
  output logic                 resp_error_o,
  output logic                 mem_req_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_wdata_o,
  output logic [3:0]           mem_be_o,
  input  logic [31:0]          mem_rdata_i
);

  localparam int unsigned MetaWidth = $bits(metadata_t);

  typedef struct packed {
    logic [31:0] rdata;
    metadata_t   meta;
    logic        lrwait;
    logic        error;
  } resp_t;

  lrwait_state_e        state_q, state_d;
  logic                 valid_q, valid_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  metadata_t            head_q, head_d, tail_q, tail_d;
  logic                 pending_q, pending_d;
  metadata_t            pending_meta_q, pending_meta_d;

  logic  is_wake, is_lr, is_sc, addr_match, needs_local, accept;
  logic  local_push, fifo_full, fifo_empty, fifo_push, fifo_usage_unused;
  resp_t local_resp, fifo_in, fifo_out;

  assign is_wake     = req_lrwait_i;
  assign is_lr       = !req_lrwait_i && (req_amo_i == LRWAIT);
  assign is_sc       = !req_lrwait_i && (req_amo_i == SCWAIT);
  assign addr_match  = valid_q && (req_addr_i == addr_q);
  assign needs_local = (is_lr && (state_q != QFree)) || is_sc;

  // A bank read in flight owns next cycle's push, so a request answering locally waits one cycle.
  assign req_ready_o = !rst_i && !fifo_full && !(pending_q && (!fifo_empty || needs_local));
  assign accept      = req_valid_i && req_ready_o;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    addr_d         = addr_q;
    head_d         = head_q;
    tail_d         = tail_q;
    pending_d      = 1'b0;
    pending_meta_d = pending_meta_q;
    mem_req_o      = 1'b0;
    mem_addr_o     = '0;
    mem_write_o    = 1'b0;
    mem_wdata_o    = '0;
    mem_be_o       = '0;
    local_push     = 1'b0;
    local_resp     = '0;
    if (accept) begin
      if (is_wake) begin
        if (state_q == QWaitWakeUp) begin
          head_d         = metadata_t'(req_wdata_i[MetaWidth-1:0]);
          mem_req_o      = 1'b1;
          mem_addr_o     = addr_q;
          mem_be_o       = 4'hF;
          pending_d      = 1'b1;
          pending_meta_d = metadata_t'(req_wdata_i[MetaWidth-1:0]);
          state_d        = QLocked;
        end
      end else if (is_lr) begin
        if (state_q == QFree) begin
          addr_d         = req_addr_i;
          head_d         = req_meta_i;
          tail_d         = req_meta_i;
          valid_d        = 1'b1;
          mem_req_o      = 1'b1;
          mem_addr_o     = req_addr_i;
          mem_be_o       = req_be_i;
          pending_d      = 1'b1;
          pending_meta_d = req_meta_i;
          state_d        = QLocked;
        end else if (addr_match) begin
          // SuccUpdate tells the old tail who queued behind it.
          local_push        = 1'b1;
          local_resp.rdata  = 32'(req_meta_i);
          local_resp.meta   = tail_q;
          local_resp.lrwait = 1'b1;
          tail_d            = req_meta_i;
        end else begin
          local_push       = 1'b1;
          local_resp.meta  = req_meta_i;
          local_resp.error = 1'b1;
        end
      end else if (is_sc) begin
        local_push      = 1'b1;
        local_resp.meta = req_meta_i;
        if ((state_q == QLocked) && addr_match && (req_meta_i == head_q)) begin
          mem_req_o   = 1'b1;
          mem_addr_o  = req_addr_i;
          mem_write_o = 1'b1;
          mem_wdata_o = req_wdata_i;
          mem_be_o    = req_be_i;
          if (head_q == tail_q) begin
            state_d = QFree;
            valid_d = 1'b0;
          end else begin
            state_d = QWaitWakeUp;
          end
        end else begin
          local_resp.rdata = 32'd1;
        end
      end else begin
        mem_req_o      = 1'b1;
        mem_addr_o     = req_addr_i;
        mem_write_o    = req_write_i;
        mem_wdata_o    = req_wdata_i;
        mem_be_o       = req_be_i;
        pending_d      = 1'b1;
        pending_meta_d = req_meta_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= QFree;
      valid_q        <= 1'b0;
      addr_q         <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      pending_q      <= 1'b0;
      pending_meta_q <= '0;
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      addr_q         <= addr_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      pending_q      <= pending_d;
      pending_meta_q <= pending_meta_d;
    end
  end

  assign fifo_push = pending_q || local_push;
  assign fifo_in   = pending_q ? resp_t'{rdata: mem_rdata_i, meta: pending_meta_q, lrwait: 1'b0, error: 1'b0}
                               : local_resp;

  fifo_v3 #(
    .DEPTH (2),
    .dtype (resp_t)
  ) i_resp_fifo (
    .clk_i      (clk_i),
    .rst_ni     (~rst_i),
    .flush_i    (1'b0),
    .testmode_i (1'b0),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .usage_o    (fifo_usage_unused),
    .data_i     (fifo_in),
    .push_i     (fifo_push),
    .data_o     (fifo_out),
    .pop_i      (resp_valid_o && resp_ready_i)
  );

  assign resp_valid_o  = !fifo_empty;
  assign resp_rdata_o  = resp_valid_o ? fifo_out.rdata  : '0;
  assign resp_meta_o   = resp_valid_o ? fifo_out.meta   : '0;
  assign resp_lrwait_o = resp_valid_o && fifo_out.lrwait;
  assign resp_error_o  = resp_valid_o && fifo_out.error;

  wakeup_only_when_waiting: assert property (@(posedge clk_i) disable iff (rst_i)
    (accept && req_lrwait_i) |-> (state_q == QWaitWakeUp));

endmodule

// File: doc/lrwait_queue_ctrl.md
LRWAIT_QUEUE_CTRL -- requirements
Module: lrwait_queue_ctrl

Interface
REQ-001 SHALL have parameter metadata_t, default logic; requester metadata carried on requests and echoed on responses, and $bits(metadata_t) <= 32.
REQ-002 SHALL have parameter AddrWidth, default 32; bank word address width.
REQ-003 SHALL have ports clk_i in 1 clock; rst_i in 1 reset. Reset is asynchronous and active-high.
REQ-004 SHALL have request ports: req_valid_i in 1; req_ready_o out 1; req_addr_i in AddrWidth; req_write_i in 1; req_amo_i in 4 (amo_op_t); req_wdata_i in 32; req_be_i in 4; req_meta_i in metadata_t; req_lrwait_i in 1 (WakeUp flag).
REQ-005 SHALL have response ports: resp_valid_o out 1; resp_ready_i in 1; resp_rdata_o out 32; resp_meta_o out metadata_t; resp_lrwait_o out 1 (SuccUpdate flag); resp_error_o out 1.
REQ-006 SHALL have bank ports: mem_req_o out 1; mem_addr_o out AddrWidth; mem_write_o out 1; mem_wdata_o out 32; mem_be_o out 4; mem_rdata_i in 32. The bank is always ready, and read data is valid exactly 1 cycle after mem_req_o.

Function
REQ-007 SHALL hold one reservation queue: valid, addr, head meta, tail meta, and FSM state Free/Locked/WaitWakeUp.
REQ-008 SHALL forward every non-LRWAIT/SCWAIT request unchanged to the bank in the accept cycle, and its read response SHALL be returned with the request meta.
REQ-009 SHALL, for LRWAIT in Free, set addr/head/tail from the request, issue a bank read, return the read data as the LRWaitResp, and move to Locked.
REQ-010 SHALL, for LRWAIT in Locked/WaitWakeUp with a matching addr, make no bank access and emit a SuccUpdate to the old tail: resp_lrwait_o=1, resp_meta_o=old tail meta, resp_rdata_o[$bits(metadata_t)-1:0]=new meta, upper bits 0. The tail SHALL then be set to the new meta, and the new requester's response is deferred.
REQ-011 SHALL, for LRWAIT with a mismatching addr while the queue is not Free, return resp_error_o=1 and rdata 0 with no bank access and no state change.
REQ-012 SHALL, for SCWAIT in Locked whose meta equals head and whose addr matches, issue a bank write and respond rdata 0. If head==tail it SHALL go to Free; otherwise it SHALL go to WaitWakeUp.
REQ-013 SHALL, for any other SCWAIT, make no bank write and respond rdata 1 (failure).
REQ-014 SHALL, for a WakeUp (req_lrwait_i=1) in WaitWakeUp, set head=req_wdata_i meta field, issue a bank read at addr, respond to the new head with resp_meta_o=new head and resp_lrwait_o=0, and go to Locked.
REQ-015 SHALL ignore a WakeUp in any other state, with no response and no bank access, and flag it with a simulation assertion.
REQ-016 SHALL buffer responses in a 2-entry FIFO.
REQ-017 SHALL drive req_ready_o=1 only when FIFO occupancy plus any in-flight bank read is < 2.
REQ-018 SHALL push locally generated responses in the accept cycle and push bank responses 1 cycle later, so that each request produces at most one push, in order.
REQ-019 SHALL expose responses directly from the FIFO head: resp_valid_o = FIFO not empty.
REQ-020 SHALL, for WakeUp and LRWAIT accepted in the same cycle, process them in request order; a single request port precludes simultaneity.
REQ-021 SHALL keep the FIFO intact on FIFO full with resp_ready_i=0, with no accept and no state change.
REQ-022 SHALL never let plain stores to a reserved addr alter the queue.

Reset
REQ-023 SHALL on rst_i=1 immediately clear the FSM to Free, valid to 0, the FIFO to empty, and the in-flight flag to 0.
REQ-024 SHALL hold every output at 0 during reset except req_ready_o=0; req_ready_o=1 from the first cycle after deassertion.
REQ-025 SHALL abandon any in-flight bank read or queue on a reset mid-operation, with no response delivered.

Structure
REQ-026 SHALL take amo_op_t (LRWAIT=4'hC, SCWAIT=4'hD) from a shared package, snitch_pkg.
REQ-027 SHALL instantiate the response FIFO as fifo_v3 (common_cells), depth 2, over a struct {rdata, meta, lrwait, error}.
REQ-028 SHALL have no other sub-module.

Verification
REQ-029 SHALL check: LRWAIT addr 0x40 meta A, bank word 0x55 -> 1 cycle later resp rdata 0x55, meta A, lrwait 0; state Locked.
REQ-030 SHALL check: then LRWAIT 0x40 meta B -> resp to A with lrwait 1, rdata=B, no mem_req_o; tail=B.
REQ-031 SHALL check: then SCWAIT 0x40 meta A, data 0x77 -> mem write 0x77, resp rdata 0; WakeUp data=B -> bank read, resp meta B, rdata 0x77.
REQ-032 SHALL check: SCWAIT 0x40 meta C (not head) -> resp rdata 1, no write; LRWAIT 0x80 while locked -> resp_error_o=1.
REQ-033 SHALL check: hold resp_ready_i=0 across 3 reads -> req_ready_o drops after 2 accepted, and the responses drain in order once released.
REQ-034 SHALL check: assert rst_i while in WaitWakeUp with 1 FIFO entry -> resp_valid_o=0 the same cycle; a fresh LRWAIT succeeds.
